// File: rtl/psum_drain.sv
// psum_drain: receive endpoint for the systolic array's partial-sum stream.
// Captures W-word beats into a small beat FIFO, then unpacks each beat into
// single words on a ready/valid port, MSB lane first. It also counts beats
// against a programmed layer total and reports completion, overflow and
// excess beats.
module psum_drain #(
    parameter int C_WIDTH          = 32,
    parameter int C_WORDS_PER_BEAT = 4,
    parameter int FIFO_DEPTH       = 16,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [CNT_WIDTH-1:0]                  total_beats,
    input  logic [C_WIDTH*C_WORDS_PER_BEAT-1:0]   in_data,
    input  logic                                  in_valid,
    output logic [C_WIDTH-1:0]                    out_word,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow,
    output logic                                  extra_beat,
    output logic [CNT_WIDTH-1:0]                  beats_rcvd
);

    localparam int W      = C_WORDS_PER_BEAT;
    localparam int BEAT_W = C_WIDTH * W;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IDX_W  = (W > 1) ? $clog2(W) : 1;

    localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]      ONE_CNT   = (AW + 1)'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Layer bookkeeping
    logic [CNT_WIDTH-1:0] total_reg;
    logic [CNT_WIDTH-1:0] beats_reg;
    logic                 overflow_reg;
    logic                 extra_reg;

    // Beat FIFO storage and pointers; occupancy kept separately so full and
    // empty never need pointer comparison.
    logic [BEAT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;

    // Which word of the head beat is currently presented.
    logic [IDX_W-1:0]  idx_reg;

    // Datapath control
    logic fifo_empty;
    logic fifo_full;
    logic in_run;
    logic start_acc;
    logic quota_open;
    logic want_push;
    logic push;
    logic pop;
    logic handshake;
    logic head_last;
    logic drop_ovf;
    logic drop_extra;
    logic last_word;

    logic [BEAT_W-1:0]  head_beat;
    logic [C_WIDTH-1:0] head_words [W];

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_CNT);
    assign in_run     = (state_reg == S_RUN);
    assign start_acc  = start && !in_run;
    assign quota_open = (beats_reg < total_reg);

    assign handshake  = !fifo_empty && out_ready;
    assign head_last  = (idx_reg == IDX_LAST);
    assign pop        = handshake && head_last;

    // A beat is wanted whenever the layer still has quota; it only lands if
    // there is room now, counting the slot freed by a same-cycle pop.
    assign want_push  = in_run && in_valid && quota_open;
    assign push       = want_push && (!fifo_full || pop);
    assign drop_ovf   = want_push && !push;
    assign drop_extra = in_valid && !want_push;

    assign last_word  = !fifo_empty && (beats_reg == total_reg)
                        && (count_reg == ONE_CNT) && head_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: arm on start, finish on the final word handshake
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = (total_beats == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_word && out_ready) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded status outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Layer total, beat count and sticky error flags; start clears the flags
    // even if a stray beat arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_reg    <= '0;
            beats_reg    <= '0;
            overflow_reg <= 1'b0;
            extra_reg    <= 1'b0;
        end else if (start_acc) begin
            total_reg    <= total_beats;
            beats_reg    <= '0;
            overflow_reg <= 1'b0;
            extra_reg    <= 1'b0;
        end else begin
            if (push) begin
                beats_reg <= beats_reg + CNT_WIDTH'(1);
            end
            if (drop_ovf) begin
                overflow_reg <= 1'b1;
            end
            if (drop_extra) begin
                extra_reg <= 1'b1;
            end
        end
    end

    // Beat storage write port; contents need no reset since occupancy gates use
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + ONE_CNT;
                2'b01:   count_reg <= count_reg - ONE_CNT;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Word index within the head beat; wraps when the head beat is retired
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg <= '0;
        end else if (handshake) begin
            idx_reg <= head_last ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // Head beat split into words, index 0 being the most significant lane
    assign head_beat = mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_lane
            assign head_words[gi] = head_beat[(W - 1 - gi) * C_WIDTH +: C_WIDTH];
        end
    endgenerate

    // Output word is forced to zero when nothing is queued so an idle port
    // never shows stale storage contents.
    assign out_valid  = !fifo_empty;
    assign out_word   = fifo_empty ? '0 : head_words[idx_reg];
    assign out_last   = last_word;
    assign overflow   = overflow_reg;
    assign extra_beat = extra_reg;
    assign beats_rcvd = beats_reg;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed scenarios for psum_drain with a word-queue model
// checked every cycle, plus literal expectations for each scenario.
module tb_psum_drain;

    localparam int CW    = 32;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CNTW  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [CNTW-1:0] total_beats = '0;
    logic [CW*W-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic [CW-1:0]   out_word;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_last;
    logic            busy;
    logic            done;
    logic            overflow;
    logic            extra_beat;
    logic [CNTW-1:0] beats_rcvd;

    always #5 clk = ~clk;

    psum_drain #(
        .C_WIDTH          (CW),
        .C_WORDS_PER_BEAT (W),
        .FIFO_DEPTH       (DEPTH),
        .CNT_WIDTH        (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .total_beats (total_beats),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_word    (out_word),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .extra_beat  (extra_beat),
        .beats_rcvd  (beats_rcvd)
    );

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Words seen leaving the DUT (with their last flags)
    logic [CW-1:0] cap_w [$];
    bit            cap_l [$];

    // Model: layer state (0 idle, 1 run, 2 done) and the queue of words
    // still owed to the consumer.
    int            m_st = 0;
    logic [CW-1:0] m_words [$];
    longint        m_total = 0;
    longint        m_beats = 0;
    bit            m_ovf = 1'b0;
    bit            m_extra = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 60)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start       = 1'b1;
        total_beats = CNTW'(n);
        tick();
        start       = 1'b0;
    endtask

    task automatic send_beat(input logic [CW*W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) tick();
        chk("done_wait", 64'(done), 64'd1);
    endtask

    function automatic logic [CW*W-1:0] mk(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c, input logic [CW-1:0] d);
        return {a, b, c, d};
    endfunction

    // The basic two-beat layer, also replayed after a mid-layer reset
    task automatic run_s1();
        logic [CW-1:0] exp_w [8];
        exp_w = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd8, 32'd7, 32'd6, 32'd5};
        cap_w.delete();
        cap_l.delete();
        out_ready = 1'b1;
        do_start(2);
        chk("s1_valid_before", 64'(out_valid), 64'd0);
        send_beat(mk(32'd4, 32'd3, 32'd2, 32'd1));
        chk("s1_valid_latency", 64'(out_valid), 64'd1);
        send_beat(mk(32'd8, 32'd7, 32'd6, 32'd5));
        wait_done(40);
        chk("s1_word_count", 64'(cap_w.size()), 64'd8);
        for (int i = 0; i < 8 && i < cap_w.size(); i++) begin
            chk($sformatf("s1_word%0d", i), 64'(cap_w[i]), 64'(exp_w[i]));
            chk($sformatf("s1_last%0d", i), 64'(cap_l[i]), (i == 7) ? 64'd1 : 64'd0);
        end
        chk("s1_beats_rcvd", 64'(beats_rcvd), 64'd2);
    endtask

    initial begin
        fork
            // Watchdog: the run is short, so this only fires on a hang
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
                $fatal(1, "watchdog");
            end
            // Model update on every rising edge from the same inputs the DUT sees
            forever begin
                @(posedge clk);
                if (rst) begin
                    m_st = 0;
                    m_words.delete();
                    m_total = 0;
                    m_beats = 0;
                    m_ovf = 1'b0;
                    m_extra = 1'b0;
                end else begin
                    int  n;
                    int  head_left;
                    int  occ;
                    bit  hs, pop, last_hs, may, push, running;
                    n         = m_words.size();
                    hs        = (n > 0) && out_ready;
                    head_left = (n % W == 0) ? W : (n % W);
                    pop       = hs && (head_left == 1);
                    occ       = (n + W - 1) / W;
                    running   = (m_st == 1);
                    last_hs   = hs && running && (n == 1) && (m_beats == m_total);
                    may       = running && in_valid && (m_beats < m_total);
                    push      = may && ((occ < DEPTH) || pop);
                    if (hs) void'(m_words.pop_front());
                    if (push) begin
                        for (int k = 0; k < W; k++)
                            m_words.push_back(in_data[(W - 1 - k) * CW +: CW]);
                        m_beats++;
                    end
                    if (may && !push) m_ovf = 1'b1;
                    if (in_valid && !may) m_extra = 1'b1;
                    if (!running && start) begin
                        m_total = longint'(total_beats);
                        m_beats = 0;
                        m_ovf   = 1'b0;
                        m_extra = 1'b0;
                        m_st    = (total_beats == '0) ? 2 : 1;
                    end else if (last_hs) begin
                        m_st = 2;
                    end
                end
            end
            // Capture accepted words and compare all outputs with the model
            forever begin
                @(negedge clk);
                if (!rst && out_valid === 1'b1 && out_ready) begin
                    cap_w.push_back(out_word);
                    cap_l.push_back(out_last);
                end
                if (cmp_en) begin
                    bit exp_valid;
                    bit exp_last;
                    exp_valid = (m_words.size() > 0);
                    exp_last  = exp_valid && (m_words.size() == 1) && (m_beats == m_total);
                    chk("cyc_out_valid", 64'(out_valid), 64'(exp_valid));
                    if (exp_valid) chk("cyc_out_word", 64'(out_word), 64'(m_words[0]));
                    chk("cyc_out_last", 64'(out_last), 64'(exp_last));
                    chk("cyc_busy", 64'(busy), (m_st == 1) ? 64'd1 : 64'd0);
                    chk("cyc_done", 64'(done), (m_st == 2) ? 64'd1 : 64'd0);
                    chk("cyc_overflow", 64'(overflow), 64'(m_ovf));
                    chk("cyc_extra_beat", 64'(extra_beat), 64'(m_extra));
                    chk("cyc_beats_rcvd", 64'(beats_rcvd), 64'(m_beats));
                end
            end
        join_none

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_beats_rcvd", 64'(beats_rcvd), 64'd0);
        chk("rst_out_word", 64'(out_word), 64'd0);

        // 1: two beats, consumer always ready
        run_s1();

        // 2: three beats held behind a 10-cycle stall
        cap_w.delete();
        cap_l.delete();
        out_ready = 1'b0;
        do_start(3);
        send_beat(mk(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        send_beat(mk(32'hB0, 32'hB1, 32'hB2, 32'hB3));
        send_beat(mk(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        for (int i = 0; i < 7; i++) begin
            chk("s2_stall_word", 64'(out_word), 64'hA0);
            tick();
        end
        chk("s2_stall_word_end", 64'(out_word), 64'hA0);
        out_ready = 1'b1;
        wait_done(40);
        chk("s2_word_count", 64'(cap_w.size()), 64'd12);
        for (int i = 0; i < 12 && i < cap_w.size(); i++)
            chk($sformatf("s2_word%0d", i), 64'(cap_w[i]),
                64'(32'hA0 + 32'h10 * (i / W) + (i % W)));
        chk("s2_overflow", 64'(overflow), 64'd0);

        // 3: five back-to-back beats into a four-deep FIFO with no consumer
        out_ready = 1'b0;
        do_start(8);
        for (int i = 0; i < 4; i++) send_beat(mk(32'(i), 32'(i + 1), 32'(i + 2), 32'(i + 3)));
        chk("s3_overflow_pre", 64'(overflow), 64'd0);
        send_beat(mk(32'h55, 32'h56, 32'h57, 32'h58));
        chk("s3_overflow", 64'(overflow), 64'd1);
        chk("s3_beats_rcvd", 64'(beats_rcvd), 64'd4);
        chk("s3_busy", 64'(busy), 64'd1);
        chk("s3_head_word", 64'(out_word), 64'd0);
        pulse_rst();

        // 4: one-beat layer followed by an excess beat
        cap_w.delete();
        cap_l.delete();
        out_ready = 1'b1;
        do_start(1);
        send_beat(mk(32'hD3, 32'hD2, 32'hD1, 32'hD0));
        send_beat(mk(32'hEE, 32'hEE, 32'hEE, 32'hEE));
        wait_done(40);
        tick();
        chk("s4_word_count", 64'(cap_w.size()), 64'd4);
        if (cap_w.size() > 0) chk("s4_last_word", 64'(cap_w[cap_w.size() - 1]), 64'hD0);
        chk("s4_extra_beat", 64'(extra_beat), 64'd1);
        chk("s4_done", 64'(done), 64'd1);
        chk("s4_beats_rcvd", 64'(beats_rcvd), 64'd1);

        // 5: empty layer, stray beat in DONE, cleared by the next start
        pulse_rst();
        chk("s5_done_pre", 64'(done), 64'd0);
        do_start(0);
        chk("s5_done", 64'(done), 64'd1);
        chk("s5_out_valid", 64'(out_valid), 64'd0);
        send_beat(mk(32'h1, 32'h2, 32'h3, 32'h4));
        chk("s5_extra_beat", 64'(extra_beat), 64'd1);
        chk("s5_no_valid", 64'(out_valid), 64'd0);
        do_start(0);
        chk("s5_extra_cleared", 64'(extra_beat), 64'd0);
        chk("s5_done_again", 64'(done), 64'd1);

        // 6: reset after six words of a two-beat layer, then a clean rerun
        pulse_rst();
        cap_w.delete();
        cap_l.delete();
        out_ready = 1'b1;
        do_start(2);
        send_beat(mk(32'd4, 32'd3, 32'd2, 32'd1));
        send_beat(mk(32'd8, 32'd7, 32'd6, 32'd5));
        for (int i = 0; i < 40 && cap_w.size() < 6; i++) tick();
        chk("s6_six_words", 64'(cap_w.size()), 64'd6);
        rst = 1'b1;
        tick();
        chk("s6_out_valid", 64'(out_valid), 64'd0);
        chk("s6_busy", 64'(busy), 64'd0);
        chk("s6_beats_rcvd", 64'(beats_rcvd), 64'd0);
        rst = 1'b0;
        run_s1();

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
Receive-side endpoint for the systolic array's partial-sum output stream. It captures valid psum beats, `C_WORDS_PER_BEAT` words wide, into a beat FIFO and unpacks each beat into single words. Words leave one per cycle on a ready/valid port toward the output writer/DMA. It counts beats against a programmed layer total and flags completion, overflow and excess beats, replacing bench-side beat counting and lane reordering.

Parameters:
C_WIDTH, 32, bits per psum word
C_WORDS_PER_BEAT, 4, words per array output beat (W)
FIFO_DEPTH, 16, beat FIFO depth; power of two, >=2
CNT_WIDTH, 32, width of beat/word counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; arms a new layer (IDLE/DONE only)
total_beats  in  CNT_WIDTH  beats expected for the layer; sampled on start
in_data  in  C_WIDTH*W  psum beat from the array (array data_out)
in_valid  in  1  beat qualifier (array valid_out); no backpressure to the array
out_word  out  C_WIDTH  current output word
out_valid  out  1  out_word valid
out_ready  in  1  consumer accepts out_word when out_valid&&out_ready
out_last  out  1  high with the final word of the layer
busy  out  1  state==RUN
done  out  1  level, high in DONE
overflow  out  1  sticky: beat arrived while FIFO full and no pop that cycle
extra_beat  out  1  sticky: in_valid seen after total_beats accepted, or in IDLE/DONE
beats_rcvd  out  CNT_WIDTH  beats accepted this layer

Behaviour:
- Reset (any cycle, including mid-layer): state IDLE, FIFO emptied, word index 0, and all counters cleared. All outputs are 0 until the next start.
- States:
  - IDLE: wait for start.
  - RUN: accept beats.
  - DONE: hold until start.
- IDLE/DONE + start: latch total_beats, clear beats_rcvd, overflow and extra_beat.
  - total_beats==0: go directly to DONE on the next cycle.
  - otherwise: go to RUN.
  - start while in RUN is ignored.
- Push: in RUN, with in_valid, beats_rcvd<total_beats, and FIFO not full (or full with a pop of the head beat this same cycle). The beat is written and beats_rcvd increments.
- in_valid while FIFO full with no pop: beat dropped, overflow set, beats_rcvd unchanged.
- in_valid in RUN after beats_rcvd==total_beats, or in IDLE/DONE: beat dropped, extra_beat set.
- Lane order: word 0 emitted = in_data[W*C_WIDTH-1 -: C_WIDTH] (MSB lane first), then descending. The last word emitted = in_data[C_WIDTH-1:0].
- Latency: a beat pushed at edge t gives out_valid=1 in cycle t+1. out_word is driven from the registered FIFO head.
- out_valid = FIFO not empty. out_word/out_valid hold stable while out_valid && !out_ready.
- On handshake:
  - word index increments.
  - At index W-1 the index wraps to 0 and the head beat pops. Push and pop in the same cycle are allowed at any occupancy.
- Throughput: 1 word/cycle out, up to 1 beat/cycle in. Sustained input therefore overflows unless FIFO_DEPTH covers the burst; this is by design and is flagged by overflow.
- out_last = out_valid && beats_rcvd==total_beats && FIFO holds exactly 1 beat && index==W-1.
- RUN->DONE on the handshake of the out_last word; done asserts the following cycle.
- If overflow drops beats, the layer never completes. busy stays high; recovery is by rst.
- Pointers wrap modulo FIFO_DEPTH, with a separate occupancy count of log2(FIFO_DEPTH)+1 bits.

Test Plan:
1. rst, start with total_beats=2, W=4. Beats 0x00000004_00000003_00000002_00000001, then 0x8_7_6_5, with out_ready=1. Required: words 4,3,2,1,8,7,6,5; out_valid 1 cycle after the first beat; out_last on word 5; done the next cycle; beats_rcvd=2.
2. total_beats=3, out_ready held 0 for 10 cycles, then 1. Required: out_word stable and equal to the first word while stalled; all 12 words in order; no overflow.
3. FIFO_DEPTH=4, out_ready=0, 5 back-to-back beats. Required: first 4 beats accepted, overflow=1 on the 5th, beats_rcvd=4, busy stays 1.
4. total_beats=1, two beats sent. Required: second beat dropped, extra_beat=1, only 4 words out, done=1.
5. Start with total_beats=0. Required: DONE after 1 cycle, no out_valid. In_valid in DONE sets extra_beat; the next start clears it.
6. Assert rst mid-layer after 6 words output. Required: out_valid=0, busy=0, beats_rcvd=0 next cycle; a fresh start then runs scenario 1 correctly.
